// File: rtl/seg_display_ctrl_if.sv
// Request/response bundle for seg_display_ctrl: conversion request in, committed segment data out.
// Handshake: start is taken on a rising edge where ready=1; each taken start yields exactly one done pulse.
interface seg_display_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int DIGITS = 4,
    parameter int WIDTH  = 10
);
    logic                         start;
    logic                         signed_mode;
    logic [NUM_CH*WIDTH-1:0]      values;
    logic                         ready;
    logic                         done;
    logic [NUM_CH-1:0]            overflow;
    logic [NUM_CH*DIGITS*8-1:0]   seg;

    modport master (
        output start, signed_mode, values,
        input  ready, done, overflow, seg
    );

    modport slave (
        input  start, signed_mode, values,
        output ready, done, overflow, seg
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Multi-channel binary-to-seven-segment controller using a shared iterative double-dabble engine.
// Optional leading-zero blanking is enabled by defining SEG_DISPLAY_LZB_EN.
module seg_display_ctrl #(
    parameter int NUM_CH = 2,
    parameter int DIGITS = 4,
    parameter int WIDTH  = 10
) (
    input  logic                Clk,
    input  logic                Reset_n,
    seg_display_ctrl_if.slave   disp,
    output logic [2:0]          dbg_state_o
);

    // Decimal digits of 2^WIDTH-1 is floor(WIDTH*log10(2))+1; keep at least the displayed digits.
    localparam int BCD_MIN = (WIDTH * 30103) / 100000 + 1;
    localparam int BCD_N   = (BCD_MIN > DIGITS - 1) ? BCD_MIN : DIGITS - 1;
    localparam int BW      = BCD_N * 4;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W   = $clog2(WIDTH);
    localparam int DW      = DIGITS * 8;
    localparam int SEGW    = NUM_CH * DW;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CH*WIDTH-1:0]  vals_q;
    logic                     smode_q;
    logic [CH_W-1:0]          ch_q;
    logic                     neg_q;
    logic [WIDTH-1:0]         mag_q;
    logic [BW-1:0]            bcd_q;
    logic [BIT_W-1:0]         bit_q;
    logic [SEGW-1:0]          shadow_q;
    logic [NUM_CH-1:0]        shadow_ov_q;
    logic [SEGW-1:0]          seg_q;
    logic [NUM_CH-1:0]        ov_q;
    logic                     done_q;

    logic [WIDTH-1:0]         cur_v;
    logic                     neg_w;
    logic [WIDTH-1:0]         mag_w;
    logic [BW-1:0]            bcd_adj;
    logic [BW+WIDTH-1:0]      sh_w;
    logic                     ov_w;
    logic [DW-1:0]            pat_w;
`ifdef SEG_DISPLAY_LZB_EN
    logic                     seen;
`endif

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        case (n)
            4'd0:    seg_enc = 8'hC0;
            4'd1:    seg_enc = 8'hF9;
            4'd2:    seg_enc = 8'hA4;
            4'd3:    seg_enc = 8'hB0;
            4'd4:    seg_enc = 8'h99;
            4'd5:    seg_enc = 8'h92;
            4'd6:    seg_enc = 8'h82;
            4'd7:    seg_enc = 8'hF8;
            4'd8:    seg_enc = 8'h80;
            4'd9:    seg_enc = 8'h90;
            default: seg_enc = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (disp.start) state_d = S_LOAD;
            S_LOAD:   state_d = S_SHIFT;
            S_SHIFT:  if (bit_q == '0) state_d = S_STORE;
            S_STORE:  state_d = (ch_q == LAST_CH) ? S_COMMIT : S_LOAD;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Two's complement negate in WIDTH bits; the most negative value maps to its correct magnitude.
    always_comb begin
        cur_v = vals_q[int'(ch_q)*WIDTH +: WIDTH];
        neg_w = smode_q & cur_v[WIDTH-1];
        mag_w = neg_w ? (~cur_v + 1'b1) : cur_v;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        sh_w = {bcd_adj, mag_q} << 1;
    end

    always_comb begin
        ov_w = 1'b0;
        for (int i = DIGITS - 1; i < BCD_N; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) ov_w = 1'b1;
        end
        pat_w = '1;
`ifdef SEG_DISPLAY_LZB_EN
        seen = 1'b0;
`endif
        if (ov_w) begin
            pat_w = {DIGITS{8'hBF}};
        end else begin
            pat_w[(DIGITS-1)*8 +: 8] = neg_q ? 8'hBF : 8'hFF;
            for (int d = DIGITS - 2; d >= 0; d--) begin
`ifdef SEG_DISPLAY_LZB_EN
                if (bcd_q[d*4 +: 4] != 4'd0 || d == 0) seen = 1'b1;
                pat_w[d*8 +: 8] = seen ? seg_enc(bcd_q[d*4 +: 4]) : 8'hFF;
`else
                pat_w[d*8 +: 8] = seg_enc(bcd_q[d*4 +: 4]);
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vals_q      <= '0;
            smode_q     <= 1'b0;
            ch_q        <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            bit_q       <= '0;
            shadow_q    <= '1;
            shadow_ov_q <= '0;
            seg_q       <= '1;
            ov_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (disp.start) begin
                        vals_q  <= disp.values;
                        smode_q <= disp.signed_mode;
                        ch_q    <= '0;
                    end
                end
                S_LOAD: begin
                    neg_q <= neg_w;
                    mag_q <= mag_w;
                    bcd_q <= '0;
                    bit_q <= LAST_BIT;
                end
                S_SHIFT: begin
                    {bcd_q, mag_q} <= sh_w;
                    bit_q          <= bit_q - 1'b1;
                end
                S_STORE: begin
                    shadow_q[int'(ch_q)*DW +: DW] <= pat_w;
                    shadow_ov_q[ch_q]             <= ov_w;
                    ch_q                          <= ch_q + 1'b1;
                end
                // Whole update becomes visible at once, together with the done pulse.
                S_COMMIT: begin
                    seg_q  <= shadow_q;
                    ov_q   <= shadow_ov_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign disp.ready    = (state_q == S_IDLE);
    assign disp.done     = done_q;
    assign disp.overflow = ov_q;
    assign disp.seg      = seg_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized scoreboard bench for seg_display_ctrl: driver pushes model results, monitor pops on done.
module tb_seg_display_ctrl;
  localparam int NUM_CH = 2;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 10;
  localparam int SEGW   = NUM_CH * DIGITS * 8;
  localparam int W      = NUM_CH + SEGW;
  localparam int LAT    = NUM_CH * (WIDTH + 2) + 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [2:0] dbg_state;

  seg_display_ctrl_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  seg_display_ctrl #(.NUM_CH(NUM_CH), .DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .disp        (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int exp_cyc_q[$];
  logic [SEGW-1:0] last_seg;

  // reference model: decimal arithmetic on the interpreted integer value
  function automatic logic [W-1:0] model(input logic sm, input logic [NUM_CH*WIDTH-1:0] v);
    logic [SEGW-1:0] s;
    logic [NUM_CH-1:0] ov;
    logic [WIDTH-1:0] x;
    logic [7:0] tab [10];
    int val, mag, lim, p;
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    lim = 1;
    for (int i = 0; i < DIGITS - 1; i++) lim = lim * 10;
    lim = lim - 1;
    s = '1;
    ov = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      x = v[c*WIDTH +: WIDTH];
      val = int'(x);
      if (sm && x[WIDTH-1]) val = val - (1 << WIDTH);
      mag = (val < 0) ? -val : val;
      if (mag > lim) begin
        ov[c] = 1'b1;
        for (int d = 0; d < DIGITS; d++) s[(c*DIGITS+d)*8 +: 8] = 8'hBF;
      end else begin
        s[(c*DIGITS+DIGITS-1)*8 +: 8] = (val < 0) ? 8'hBF : 8'hFF;
        p = 1;
        for (int d = 0; d < DIGITS - 1; d++) begin
`ifdef SEG_DISPLAY_LZB_EN
          if (d > 0 && mag < p) s[(c*DIGITS+d)*8 +: 8] = 8'hFF; else
`endif
          s[(c*DIGITS+d)*8 +: 8] = tab[(mag / p) % 10];
          p = p * 10;
        end
      end
    end
    return {ov, s};
  endfunction

  function automatic logic [WIDTH-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return WIDTH'(1 << (WIDTH - 1));
      3: return WIDTH'(999);
      4: return WIDTH'(1000);
      default: return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge Clk) begin
    logic [W-1:0] e;
    int ec;
    if (!Reset_n) begin
      last_seg = bus.seg;
    end else begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done at cycle %0d seg=%h", cyc, bus.seg);
        end else begin
          e = exp_q.pop_front();
          ec = exp_cyc_q.size() > 0 ? exp_cyc_q.pop_front() : -1;
          vectors++;
          if ({bus.overflow, bus.seg} !== e) begin
            miscompares++;
            $display("FAIL seg_data got ov=%b seg=%h expected ov=%b seg=%h",
                     bus.overflow, bus.seg, e[W-1:SEGW], e[SEGW-1:0]);
          end
          vectors++;
          if (cyc !== ec) begin
            miscompares++;
            $display("FAIL done_latency got cycle %0d expected cycle %0d", cyc, ec);
          end
        end
      end else begin
        vectors++;
        if (bus.seg !== last_seg) begin
          miscompares++;
          $display("FAIL seg_hold changed without done: got %h expected %h", bus.seg, last_seg);
        end
      end
      last_seg = bus.seg;
    end
  end

  task automatic check(input string name, input logic [SEGW-1:0] got, input logic [SEGW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // driver: waits for ready, issues one start, records the expected result
  task automatic issue(input logic sm, input logic [NUM_CH*WIDTH-1:0] v);
    int guard = 0;
    @(negedge Clk);
    while (!bus.ready && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (!bus.ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout got ready=0 expected ready=1");
      return;
    end
    bus.start = 1'b1;
    bus.signed_mode = sm;
    bus.values = v;
    exp_q.push_back(model(sm, v));
    @(posedge Clk);
    #1;
    exp_cyc_q.push_back(cyc + LAT);
    bus.start = 1'b0;
  endtask

  task automatic spam_until_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (bus.ready) break;
      bus.start = 1'b1;
      bus.signed_mode = 1'($urandom_range(0, 1));
      bus.values = {rand_val(), rand_val()};
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      @(posedge Clk);
      guard++;
    end
    vectors++;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.values = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_seg", bus.seg, {SEGW{1'b1}});
    check("reset_ov", SEGW'(bus.overflow), '0);
    check("reset_ready", SEGW'(bus.ready), SEGW'(1));
    check("reset_done", SEGW'(bus.done), '0);
    Reset_n = 1'b1;

    // directed vectors, issued back-to-back
    issue(1'b1, {10'h200, 10'h1F4});
    issue(1'b0, {10'd7, 10'd1023});
    issue(1'b1, {10'd0, 10'h3FF});
    wait_drain();

    // start held high during a conversion must be ignored
    issue(1'b0, {10'd123, 10'd456});
    spam_until_ready();
    issue(1'b1, {10'h2FF, 10'd999});
    spam_until_ready();
    wait_drain();

    for (int n = 0; n < 30; n++) issue(1'($urandom_range(0, 1)), {rand_val(), rand_val()});
    wait_drain();

    // asynchronous reset in the middle of SHIFT aborts without commit
    issue(1'b1, {rand_val(), rand_val()});
    repeat (8) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset_seg", bus.seg, {SEGW{1'b1}});
    check("async_reset_ov", SEGW'(bus.overflow), '0);
    check("async_reset_ready", SEGW'(bus.ready), SEGW'(1));
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
    repeat (40) @(posedge Clk);

    issue(1'b0, {rand_val(), rand_val()});
    wait_drain();
    repeat (3) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
